// File: rtl/sega_joy_pkg.sv
// Shared step numbering, mode codes and joy_o bit layout for the DB9 pad reader.
package sega_joy_pkg;

  localparam int unsigned STEP_SEL0    = 0;
  localparam int unsigned STEP_SEL1    = 1;
  localparam int unsigned STEP_CAP_LO  = 2;
  localparam int unsigned STEP_CAP_HI  = 3;
  localparam int unsigned STEP_SEL4    = 4;
  localparam int unsigned STEP_DETECT  = 5;
  localparam int unsigned STEP_CAP_XYZ = 6;
  localparam int unsigned STEP_COMMIT  = 7;

  localparam int MODE_AUTO      = 0;
  localparam int MODE_THREE_BTN = 1;
  localparam int MODE_SMS       = 2;

  localparam int BIT_U = 0;
  localparam int BIT_D = 1;
  localparam int BIT_L = 2;
  localparam int BIT_R = 3;
  localparam int BIT_B = 4;
  localparam int BIT_C = 5;
  localparam int BIT_A = 6;
  localparam int BIT_S = 7;
  localparam int BIT_Z = 8;
  localparam int BIT_Y = 9;
  localparam int BIT_X = 10;
  localparam int BIT_M = 11;

  // One-cycle action flags decoded from the step counter in the strobe cycle.
  typedef struct packed {
    logic cap_lo;
    logic cap_hi;
    logic detect;
    logic cap_xyz;
    logic commit;
  } step_act_t;

  // Select level driven from a given step; forced modes never open the third low phase.
  function automatic logic sel_for_step(input int unsigned step, input int mode);
    logic [31:0] w_s;
    w_s = step;
    if (step >= STEP_COMMIT) return 1'b1;
    if (mode != MODE_AUTO && step >= STEP_SEL4) return 1'b1;
    return w_s[0];
  endfunction

endpackage

// File: rtl/sega_joy_port.sv
// One pad's capture path: shadow frame, md/6-button detection and six_btn hysteresis.
module sega_joy_port
  import sega_joy_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  step_act_t   i_act,
  input  logic [5:0]  i_pad,
  output logic [11:0] o_joy,
  output logic        o_six_btn,
  output logic        o_md_pad
);

  localparam bit FORCE_SMS = (MODE == MODE_SMS);

  logic [11:0] r_shadow;
  logic [11:0] r_joy;
  logic        r_cand;
  logic        r_md;
  logic        r_six;
  logic        r_md_pad;
  logic [1:0]  r_cnt;

  logic       w_p9, w_p6, w_right, w_left;
  logic       w_flip;
  logic       w_six_next;
  logic [1:0] w_cnt_next;

  assign w_p9    = i_pad[5];
  assign w_p6    = i_pad[4];
  assign w_right = i_pad[3];
  assign w_left  = i_pad[2];

  // r_cnt counts consecutive scans whose cand disagrees with the current six_btn state.
  always_comb begin
    w_flip     = 1'b0;
    w_cnt_next = 2'd0;
    if (r_cand != r_six) begin
      if (r_cnt == 2'd1) w_flip = 1'b1;
      else w_cnt_next = (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
    end
    w_six_next = r_six ^ w_flip;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_shadow <= '1;
      r_joy    <= '1;
      r_cand   <= 1'b0;
      r_md     <= 1'b0;
      r_six    <= 1'b0;
      r_md_pad <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_act.cap_lo) begin
        r_shadow[5:0] <= i_pad;
        r_cand        <= 1'b0;
      end
      if (i_act.cap_hi) begin
        if (!FORCE_SMS && !w_right && !w_left) begin
          r_shadow[BIT_S:BIT_A] <= {w_p9, w_p6};
          r_md                  <= 1'b1;
        end else begin
          r_shadow[BIT_S:BIT_B] <= {2'b11, w_p9, w_p6};
          r_md                  <= 1'b0;
        end
      end
      if (i_act.detect) r_cand <= ~|i_pad[3:0];
      if (i_act.cap_xyz) r_shadow[BIT_M:BIT_Z] <= r_cand ? i_pad[3:0] : 4'hF;
      if (i_act.commit) begin
        r_joy    <= {w_six_next ? r_shadow[BIT_M:BIT_Z] : 4'hF, r_shadow[BIT_S:BIT_U]};
        r_md_pad <= r_md;
        r_six    <= w_six_next;
        r_cnt    <= w_cnt_next;
      end
    end
  end

  assign o_joy     = r_joy;
  assign o_six_btn = r_six;
  assign o_md_pad  = r_md_pad;

endmodule

// File: rtl/sega_joy_reader.sv
// DB9 Sega pad scanner: hsync-paced step sequencer driving the select line, one capture block per port.
module sega_joy_reader
  import sega_joy_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int STEP_W    = 8,
  parameter int MODE      = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    hs_i,
  input  logic [NUM_PORTS*6-1:0]  pad_i,
  output logic                    sel_o,
  output logic [NUM_PORTS*12-1:0] joy_o,
  output logic [NUM_PORTS-1:0]    six_btn_o,
  output logic [NUM_PORTS-1:0]    md_pad_o,
  output logic                    valid_o
);

  logic                   r_hs_s1, r_hs_s2, r_hs_d;
  logic [NUM_PORTS*6-1:0] r_pad_s1, r_pad_s2;
  logic [STEP_W-1:0]      r_step;
  logic                   r_sel;
  logic                   r_valid;

  logic        w_strobe;
  int unsigned w_step;
  step_act_t   w_act;

  assign w_strobe = r_hs_d & ~r_hs_s2;
  assign w_step   = 32'(r_step);

  always_comb begin
    w_act = '0;
    if (w_strobe) begin
      w_act.cap_lo  = (w_step == STEP_CAP_LO);
      w_act.cap_hi  = (w_step == STEP_CAP_HI);
      w_act.detect  = (w_step == STEP_DETECT) && (MODE == MODE_AUTO);
      w_act.cap_xyz = (w_step == STEP_CAP_XYZ) && (MODE == MODE_AUTO);
      w_act.commit  = (w_step == STEP_COMMIT);
    end
  end

  // Reset takes priority over a coincident strobe; idle-high flops avoid a false edge on release.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hs_s1  <= 1'b1;
      r_hs_s2  <= 1'b1;
      r_hs_d   <= 1'b1;
      r_pad_s1 <= '1;
      r_pad_s2 <= '1;
      r_step   <= '0;
      r_sel    <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_hs_s1  <= hs_i;
      r_hs_s2  <= r_hs_s1;
      r_hs_d   <= r_hs_s2;
      r_pad_s1 <= pad_i;
      r_pad_s2 <= r_pad_s1;
      r_valid  <= w_act.commit;
      if (w_strobe) begin
        r_step <= r_step + STEP_W'(1);
        r_sel  <= sel_for_step(w_step, MODE);
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sega_joy_port #(
      .MODE(MODE)
    ) u_port (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .i_act    (w_act),
      .i_pad    (r_pad_s2[6*p +: 6]),
      .o_joy    (joy_o[12*p +: 12]),
      .o_six_btn(six_btn_o[p]),
      .o_md_pad (md_pad_o[p])
    );
  end

  assign sel_o   = r_sel;
  assign valid_o = r_valid;

endmodule

// File: doc/sega_joy_reader.md
SEGA_JOY_READER -- requirements
Module: sega_joy_reader

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high. Ports: clk_sys and reset.
REQ-002 Parameter NUM_PORTS, default 2: number of DB9 pads, range 1..4.
REQ-003 Parameter STEP_W, default 8: width of the scan step counter; a frame is 2^STEP_W steps, with STEP_W >= 3.
REQ-004 Parameter MODE, default 0: 0 = auto-detect; 1 = force 3-button (skip steps 4-6); 2 = force Master System (2-button, no Start/A capture).
REQ-005 Ports:
- clk_sys: in, 1 bit, system clock.
- reset: in, 1 bit, synchronous active-high reset.
- hs_i: in, 1 bit, raw horizontal sync. Its falling edge is the step strobe.
- pad_i: in, NUM_PORTS*6 bits, active-low. Per port p, bits [6p+5:6p] = {p9, p6, right, left, down, up}.
- sel_o: in name only, direction out, 1 bit. Drives pin 7 (select line) of all pads.
- joy_o: out, NUM_PORTS*12 bits, active-low. Per port format is {M,X,Y,Z, S,A,C,B, R,L,D,U}, MSB first.
- six_btn_o: out, NUM_PORTS bits. High = port is recognised as a 6-button pad.
- md_pad_o: out, NUM_PORTS bits. High = port is recognised as a Mega Drive pad in the last scan.
- valid_o: out, 1 bit. One-clk pulse when joy_o updates.

Function
REQ-006 hs_i and pad_i SHALL pass through a 2-flop synchroniser. A step strobe is a high-to-low transition of the synchronised hs_i, detected in one clk_sys cycle.
REQ-007 Each strobe SHALL advance step counter s by 1. After 2^STEP_W-1 the counter wraps to 0.
- All step actions execute in the strobe cycle.
- sel_o is registered and changes in the strobe cycle.
REQ-008 sel_o per step:
- s=0: 0
- s=1: 1
- s=2: 0
- s=3: 1
- s=4: 0
- s=5: 1
- s=6: 0
- s>=7: 1
- In MODE 1 and 2, sel_o SHALL stay 1 during steps 4-6.
REQ-009 Step 2: shadow[5:0] <= {p9,p6,R,L,D,U}, and the per-port candidate flag cand <= 0.
REQ-010 Step 3 (MODE 0/1):
- If R=0 and L=0: shadow[7:6] <= {p9,p6}, and md flag <= 1.
- Otherwise: shadow[7:4] <= {1,1,p9,p6}, and md flag <= 0.
- MODE 2: always take the "otherwise" branch.
REQ-011 Step 5 (MODE 0 only): cand <= 1 if U, D, L and R are all 0.
REQ-012 Step 6 (MODE 0 only): if cand=1, shadow[11:8] <= {R,L,D,U}; otherwise shadow[11:8] <= 4'b1111.
REQ-013 Step 7 commit:
- joy_o <= shadow for all ports at once.
- md_pad_o <= md flag.
- valid_o = 1 for exactly that cycle.
- joy_o SHALL never show a partially captured frame.
REQ-014 six_btn_o hysteresis, updated at step 7:
- It sets after 2 consecutive scans with cand=1.
- It clears after 2 consecutive scans with cand=0.
- Track this with a 2-bit saturating counter per port.
- While six_btn_o=0, committed bits [11:8] SHALL be 4'b1111.
REQ-015 Simultaneous strobe and reset: reset wins, and the strobe is discarded.
REQ-016 If hs_i stops, all outputs SHALL hold. There is no timeout.
REQ-017 Ports are independent. A missing pad reads all 1s and gives joy_o all 1s, six_btn_o=0, md_pad_o=0.

Reset
REQ-018 On reset, the following SHALL take these values on the next clk_sys edge:
- s = 0
- sel_o = 1
- joy_o and shadow = all 1s
- six_btn_o = 0, md_pad_o = 0
- hysteresis counters = 0
- valid_o = 0
- synchroniser and edge flops = 1 (so no false strobe after reset)
REQ-019 Reset mid-scan SHALL discard the shadow. The first commit after reset occurs at the first step 7.

Structure
REQ-020 Package sega_joy_pkg SHALL hold:
- step constants STEP_SEL0..STEP_COMMIT
- MODE values (AUTO, THREE_BTN, SMS)
- joy_o bit-index constants (BIT_U..BIT_M)
REQ-021 Sub-module sega_joy_port SHALL hold one port's shadow, cand, md flag and hysteresis.
- It is instantiated NUM_PORTS times by a generate loop.
- The top holds the synchroniser, edge detector, step counter and sel_o.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- 3-button pad, MODE 0, pad 0 holds B and Up, and responds with L=R=0 at sel=0. Expected after 1 frame: joy_o[11:0]=12'hFEE (MXYZ=1111, S=1, A=1, C=1, B=0, RLDU=1110), md_pad_o[0]=1, six_btn_o[0]=0.
- 6-button pad, MODE 0, X held, all dirs 0 at step 5. Expected: six_btn_o=0 after frame 1 and 1 after frame 2; joy_o[10]=0 only from frame 2.
- SMS pad (R/L never both 0) holding p9, MODE 0. Expected: joy_o[7:4]=4'b1101 (S=1, A=1, C=0, B=1), md_pad_o=0.
- MODE 1 with a 6-button pad. Expected: sel_o=1 at steps 4-6, six_btn_o stays 0, joy_o[11:8]=4'hF.
- Reset asserted at step 5 of frame 1 with held inputs. Expected: joy_o=all 1s and valid_o=0 until the step-7 strobe of the next full scan, then the correct value.
- hs_i strobe cycle coincident with reset. Expected: s=0 and sel_o=1 afterward; no valid_o pulse.
